// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_pkg
//  Description : Shared types, defaults and init-pattern helper for data_mem.
//  Revision    : 1.0 - initial release
// ============================================================================
package data_mem_pkg;

    localparam int c_def_data_w = 8;
    localparam int c_def_addr_w = 5;
    localparam int c_def_depth  = 32;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Lower half counts up from 0, upper half counts down from 0 (two's complement).
    function automatic logic [63:0] init_pattern(
        input int unsigned k,
        input int unsigned data_w,
        input int unsigned depth
    );
        logic [63:0] v_half;
        logic [63:0] v_k;
        logic [63:0] v_val;
        v_half = 64'(depth >> 1);
        v_k    = 64'(k);
        if (v_k < v_half) begin
            v_val = v_k;
        end else begin
            v_val = v_half - v_k;
        end
        if (data_w < 64) begin
            v_val = v_val & ((64'd1 << data_w) - 64'd1);
        end
        return v_val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_array
//  Description : Single-port RAM, synchronous write-first read, DATA_W x DEPTH.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
                r_rdata       <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/data_mem_param.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_param
//  Description : Parametrised data memory with valid/ready access, 1-cycle
//                response, range checking and a serial init walker.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_param
    import data_mem_pkg::*;
#(
    parameter int DATA_W = c_def_data_w,
    parameter int ADDR_W = c_def_addr_w,
    parameter int DEPTH  = c_def_depth
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init_req,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_busy
);

    localparam int              c_cnt_w = ADDR_W + 1;
    localparam logic [ADDR_W:0] c_depth = c_cnt_w'(DEPTH);
    localparam logic [ADDR_W:0] c_last  = c_cnt_w'(DEPTH - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W:0]   r_walk;
    logic              r_ready;
    logic              r_busy;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic              r_rsp_data;

    logic              w_accept;
    logic              w_in_range;
    logic              w_ram_en;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_wdata;
    logic [DATA_W-1:0] w_ram_rdata;
    logic [DATA_W-1:0] w_pattern;

    assign w_in_range = ({1'b0, req_addr} < c_depth);
    assign w_accept   = req_valid & r_ready;
    assign w_pattern  = DATA_W'(init_pattern(32'(r_walk), 32'(DATA_W), 32'(DEPTH)));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            INIT:    if (r_walk == c_last) w_state_next = RUN;
            RUN:     if (init_req)         w_state_next = INIT;
            default: w_state_next = INIT;
        endcase
    end

    // The walker owns the single RAM port for the whole of INIT.
    always_comb begin
        w_ram_en    = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_addr  = req_addr;
        w_ram_wdata = req_wdata;
        if (!reset) begin
            if (r_state == INIT) begin
                w_ram_en    = 1'b1;
                w_ram_we    = 1'b1;
                w_ram_addr  = r_walk[ADDR_W-1:0];
                w_ram_wdata = w_pattern;
            end else if (w_accept && w_in_range) begin
                w_ram_en = 1'b1;
                w_ram_we = req_write;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= INIT;
            r_walk  <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_ready <= (w_state_next == RUN);
            r_busy  <= (w_state_next == INIT);
            if ((r_state == INIT) && (w_state_next == INIT)) begin
                r_walk <= r_walk + 1'b1;
            end else begin
                r_walk <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= 1'b0;
        end else begin
            r_rsp_valid <= w_accept;
            r_rsp_err   <= w_accept & ~w_in_range;
            r_rsp_data  <= w_accept & w_in_range;
        end
    end

    data_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    assign req_ready = r_ready;
    assign init_busy = r_busy;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_data ? w_ram_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_param
//  Description : Self-checking bench for data_mem_param in three configurations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_param;

    localparam int NI = 3;
    localparam int c_dw [NI] = '{8, 8, 16};
    localparam int c_aw [NI] = '{5, 5, 6};
    localparam int c_dp [NI] = '{32, 24, 64};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [NI];
    logic        ireq  [NI];
    logic        vld   [NI];
    logic        wr    [NI];
    logic [5:0]  addr  [NI];
    logic [15:0] wd    [NI];
    logic        rdy   [NI];
    logic        rv    [NI];
    logic        re    [NI];
    logic        busy  [NI];
    logic [15:0] rd    [NI];
    logic [7:0]  rd0;
    logic [7:0]  rd1;
    logic [15:0] rd2;

    assign rd[0] = {8'h00, rd0};
    assign rd[1] = {8'h00, rd1};
    assign rd[2] = rd2;

    data_mem_param #(.DATA_W(8), .ADDR_W(5), .DEPTH(32)) u_dut0 (
        .clk(clk), .reset(rst[0]), .init_req(ireq[0]), .req_valid(vld[0]),
        .req_ready(rdy[0]), .req_write(wr[0]), .req_addr(addr[0][4:0]),
        .req_wdata(wd[0][7:0]), .rsp_valid(rv[0]), .rsp_rdata(rd0),
        .rsp_err(re[0]), .init_busy(busy[0]));

    data_mem_param #(.DATA_W(8), .ADDR_W(5), .DEPTH(24)) u_dut1 (
        .clk(clk), .reset(rst[1]), .init_req(ireq[1]), .req_valid(vld[1]),
        .req_ready(rdy[1]), .req_write(wr[1]), .req_addr(addr[1][4:0]),
        .req_wdata(wd[1][7:0]), .rsp_valid(rv[1]), .rsp_rdata(rd1),
        .rsp_err(re[1]), .init_busy(busy[1]));

    data_mem_param #(.DATA_W(16), .ADDR_W(6), .DEPTH(64)) u_dut2 (
        .clk(clk), .reset(rst[2]), .init_req(ireq[2]), .req_valid(vld[2]),
        .req_ready(rdy[2]), .req_write(wr[2]), .req_addr(addr[2]),
        .req_wdata(wd[2]), .rsp_valid(rv[2]), .rsp_rdata(rd2),
        .rsp_err(re[2]), .init_busy(busy[2]));

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [15:0] model [NI][64];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] dmask(input int i);
        return 16'((32'd1 << c_dw[i]) - 1);
    endfunction

    // Upper half holds -(k - DEPTH/2) modulo the word width.
    function automatic logic [15:0] pat(input int i, input int k);
        int h;
        h = c_dp[i] / 2;
        if (k < h) return 16'(k) & dmask(i);
        return 16'(h - k) & dmask(i);
    endfunction

    task automatic init_model(input int i);
        for (int k = 0; k < 64; k++) model[i][k] = (k < c_dp[i]) ? pat(i, k) : 16'h0;
    endtask

    task automatic reset_chk(input int i);
        @(negedge clk);
        rst[i] = 1'b1; vld[i] = 1'b0; ireq[i] = 1'b0;
        @(posedge clk); #1;
        check($sformatf("d%0d reset rsp_valid", i), 32'(rv[i]), 0);
        check($sformatf("d%0d reset req_ready", i), 32'(rdy[i]), 0);
        check($sformatf("d%0d reset init_busy", i), 32'(busy[i]), 1);
        check($sformatf("d%0d reset rsp_rdata", i), 32'(rd[i]), 0);
        check($sformatf("d%0d reset rsp_err", i), 32'(re[i]), 0);
    endtask

    task automatic wait_init(input int i, input string tag);
        int n;
        int spur;
        bit done;
        n = 0; spur = 0; done = 1'b0;
        @(negedge clk);
        rst[i] = 1'b0; vld[i] = 1'b0; ireq[i] = 1'b0;
        while (!done && n < 300) begin
            @(posedge clk); #1;
            n++;
            if (rdy[i]) done = 1'b1;
            else begin
                if (rv[i]) spur++;
                if (!busy[i]) spur++;
            end
        end
        check({tag, " init length"}, 32'(n), 32'(c_dp[i]));
        check({tag, " init spurious"}, 32'(spur), 0);
        check({tag, " init_busy after"}, 32'(busy[i]), 0);
        init_model(i);
    endtask

    task automatic req(input int i, input bit w, input int a, input logic [15:0] d,
                       input bit ini, output logic [15:0] g, output logic ge, output logic gv);
        @(negedge clk);
        vld[i] = 1'b1; wr[i] = w; addr[i] = 6'(a); wd[i] = d & dmask(i); ireq[i] = ini;
        @(posedge clk); #1;
        g = rd[i]; ge = re[i]; gv = rv[i];
        vld[i] = 1'b0; ireq[i] = 1'b0;
    endtask

    task automatic req_chk(input int i, input bit w, input int a, input logic [15:0] d,
                           input bit ini, input string tag);
        logic [15:0] g;
        logic        ge;
        logic        gv;
        logic [15:0] expd;
        bit          inr;
        inr  = (a < c_dp[i]);
        expd = !inr ? 16'h0 : (w ? (d & dmask(i)) : model[i][a]);
        req(i, w, a, d, ini, g, ge, gv);
        check({tag, " rsp_valid"}, 32'(gv), 1);
        check({tag, " rsp_err"}, 32'(ge), 32'(!inr));
        check({tag, " rsp_rdata"}, 32'(g), 32'(expd));
        if (w && inr) model[i][a] = d & dmask(i);
    endtask

    task automatic rand_run(input int i, input int cnt);
        int r;
        for (int k = 0; k < cnt; k++) begin
            r = $urandom_range(0, 99);
            if (r < 10) begin
                @(negedge clk);
                vld[i] = 1'b0;
            end else if (r < 12) begin
                req_chk(i, 1'b0, $urandom_range(0, c_dp[i] - 1), 16'h0, 1'b1,
                        $sformatf("d%0d rnd reinit", i));
                check($sformatf("d%0d rnd reinit ready", i), 32'(rdy[i]), 0);
                wait_init(i, $sformatf("d%0d rnd", i));
            end else begin
                req_chk(i, 1'($urandom_range(0, 1)), $urandom_range(0, (1 << c_aw[i]) - 1),
                        16'($urandom), 1'b0, $sformatf("d%0d rnd #%0d", i, k));
            end
        end
    endtask

    logic [15:0] g;
    logic        ge;
    logic        gv;

    initial begin
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b1; ireq[i] = 1'b0; vld[i] = 1'b0; wr[i] = 1'b0;
            addr[i] = '0; wd[i] = '0;
        end

        // Default configuration
        reset_chk(0);
        wait_init(0, "d0 por");
        req(0, 1'b0, 0, 16'h0, 1'b0, g, ge, gv);  check("d0 rd@0", 32'(g), 32'h00);
        req(0, 1'b0, 15, 16'h0, 1'b0, g, ge, gv); check("d0 rd@15", 32'(g), 32'h0F);
        req(0, 1'b0, 16, 16'h0, 1'b0, g, ge, gv); check("d0 rd@16", 32'(g), 32'h00);
        req(0, 1'b0, 17, 16'h0, 1'b0, g, ge, gv); check("d0 rd@17", 32'(g), 32'hFF);
        check("d0 rd@17 err", 32'(ge), 0);
        req(0, 1'b0, 31, 16'h0, 1'b0, g, ge, gv); check("d0 rd@31", 32'(g), 32'hF1);
        check("d0 rd@31 valid", 32'(gv), 1);
        req_chk(0, 1'b1, 3, 16'hA5, 1'b0, "d0 wr A5@3");
        req(0, 1'b0, 3, 16'h0, 1'b0, g, ge, gv);  check("d0 raw @3", 32'(g), 32'hA5);
        model[0][3] = 16'hA5;

        req_chk(0, 1'b1, 5, 16'h77, 1'b0, "d0 wr 77@5");
        req(0, 1'b0, 5, 16'h0, 1'b1, g, ge, gv);  check("d0 reinit rd@5", 32'(g), 32'h77);
        check("d0 reinit rd valid", 32'(gv), 1);
        check("d0 reinit busy", 32'(busy[0]), 1);
        wait_init(0, "d0 reinit");
        req(0, 1'b0, 5, 16'h0, 1'b0, g, ge, gv);  check("d0 post-init @5", 32'(g), 32'h05);

        // Pending response dropped by reset, then reset mid-walk
        @(negedge clk);
        vld[0] = 1'b1; wr[0] = 1'b0; addr[0] = 6'd1;
        reset_chk(0);
        @(negedge clk);
        rst[0] = 1'b0;
        repeat (10) @(posedge clk);
        reset_chk(0);
        wait_init(0, "d0 midinit");
        rand_run(0, 250);

        // DEPTH=24: out-of-range behaviour
        reset_chk(1);
        wait_init(1, "d1 por");
        req(1, 1'b1, 30, 16'h55, 1'b0, g, ge, gv);
        check("d1 wr@30 err", 32'(ge), 1);
        check("d1 wr@30 data", 32'(g), 0);
        req(1, 1'b0, 30, 16'h0, 1'b0, g, ge, gv);
        check("d1 rd@30 err", 32'(ge), 1);
        req(1, 1'b0, 23, 16'h0, 1'b0, g, ge, gv);
        check("d1 rd@23", 32'(g), 32'hF5);
        check("d1 rd@23 err", 32'(ge), 0);
        rand_run(1, 250);

        // 16-bit, depth 64
        reset_chk(2);
        wait_init(2, "d2 por");
        req(2, 1'b0, 33, 16'h0, 1'b0, g, ge, gv); check("d2 rd@33", 32'(g), 32'hFFFF);
        req(2, 1'b0, 63, 16'h0, 1'b0, g, ge, gv); check("d2 rd@63", 32'(g), 32'hFFE1);
        rand_run(2, 250);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_param.md
# data_mem_param

Parametrised data memory for the single-cycle/multi-cycle CPU datapath, replacing the fixed 32×8 array. Width and depth are generic. Accesses use a valid/ready request with a registered one-cycle response. Reset, or a soft re-init request, triggers a hardware walker that rewrites the power-on pattern one entry per cycle, so large depths need no wide parallel reset. Out-of-range addresses are flagged and never corrupt the array.

## Interface
- DATA_W, 8: data word width in bits (≥2).
- ADDR_W, 5: address width in bits.
- DEPTH, 32: number of entries; even; 2 ≤ DEPTH ≤ 2**ADDR_W.

- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- init_req  in  1  one-cycle pulse that requests a re-init; sampled only in RUN.
- req_valid  in  1  request present.
- req_ready  out  1  registered; high only in RUN.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  read data, or the written data on a write ack; 0 on error.
- rsp_err  out  1  valid with rsp_valid; address ≥ DEPTH.
- init_busy  out  1  high while the walker runs.

## Operation
- States: INIT and RUN.
- Reset values:
  - state = INIT, walk counter = 0.
  - init_busy = 1, req_ready = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
- INIT:
  - Each cycle, write pattern(k) to entry k, then k++.
  - After entry DEPTH-1 is written, go to RUN. init_busy drops and req_ready rises in the same cycle.
  - Requests are not accepted during INIT.
- Init pattern:
  - pattern(k) = k for k < DEPTH/2.
  - pattern(k) = (−(k − DEPTH/2)) mod 2**DATA_W for k ≥ DEPTH/2.
  - DATA_W=8, DEPTH=32 gives 0..15, 0, 0xFF, 0xFE … 0xF1.
- RUN: a request is accepted when req_valid & req_ready.
  - Read: the response carries the array content at req_addr.
  - Write: the array is updated at the accepting edge. The ack carries req_wdata.
  - Address ≥ DEPTH: no array access, rsp_rdata = 0, rsp_err = 1.
- Re-init: init_req high in RUN means a request accepted in the same cycle is still served from pre-init contents. The next cycle enters INIT with counter 0.
- Reset mid-INIT or mid-RUN: restart INIT from 0. Any pending response is dropped, so rsp_valid = 0 the cycle after reset.
- Width rules:
  - Pattern arithmetic is modulo 2**DATA_W.
  - req_addr is compared unsigned against DEPTH.
  - The walk counter is ADDR_W+1 bits wide, so DEPTH = 2**ADDR_W terminates correctly.

## Timing
- Read and write latency: 1 cycle. Accept at edge N gives rsp_valid high for the cycle after edge N.
- Throughput: one request per cycle. Back-to-back requests produce back-to-back responses.
- Read-after-write to the same address on consecutive accepted requests returns the new data; no bubble.
- Reset deasserted before edge R (first non-reset edge):
  - Entry k is written at edge R+k.
  - req_ready is first high after edge R+DEPTH−1.
- INIT duration: exactly DEPTH cycles for both reset and init_req.
- During INIT: req_ready = 0 and rsp_valid = 0, except one trailing response for a request accepted in the init_req cycle.
- Outputs are registered. No combinational path from inputs to outputs.

## Structure
- Package data_mem_pkg holds:
  - The state enum {INIT, RUN}.
  - A function init_pattern(k, DATA_W, DEPTH).
  - Default parameter constants.
- Sub-module data_mem_array: a simple 1-port RAM with synchronous write and synchronous read, DATA_W × DEPTH.
  - The walker and the request path share its single write port through a mux selected by state.
- The top holds the FSM, walk counter, range check and response registers.

## Test plan
- Reset then idle (defaults): init_busy stays 1 for 32 cycles, then req_ready=1. Reading addresses 0, 15, 16, 17, 31 returns 0x00, 0x0F, 0x00, 0xFF, 0xF1, all with rsp_err=0.
- Write then read back: write 0xA5 @ 3 gives an ack with rsp_rdata=0xA5. A read @ 3 on the next cycle returns 0xA5. A back-to-back read/write stream yields one response per cycle.
- Out-of-range access: with DEPTH=24, ADDR_W=5:
  - Write 0x55 @ 30 gives rsp_err=1 and rsp_rdata=0.
  - A following read @ 30 gives rsp_err=1.
  - A read @ 23 returns the pattern value 0xF5.
- Re-init with a concurrent read: write 0x77 @ 5, then pulse init_req together with a read @ 5.
  - The read returns 0x77.
  - init_busy stays high for 32 cycles.
  - A later read @ 5 returns 0x05.
- Reset mid-init: assert reset at walk step 10 for 1 cycle.
  - Walker restarts at 0.
  - req_ready is first high exactly 32 cycles after reset deasserts.
  - No spurious rsp_valid.
- Parameter sweep (DATA_W=16, ADDR_W=6, DEPTH=64): entry 33 reads 0xFFFF and entry 63 reads 0xFFE1. INIT takes 64 cycles.
